// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//
// Receive-side companion to the ripple clock divider. It runs on the
// undivided clock and treats the divided clock as asynchronous data. It
// synchronizes that input and produces one-cycle rise and fall strobes in
// the fast domain. It also measures the rise-to-rise period, checks the
// 50% duty cycle against the configured divide ratio, and reports lock and
// fault status.
//
// Ports:
//   clk_hf        in   undivided clock, the only clock in this block
//   rst_n         in   asynchronous active-low reset
//   clk_div_in    in   divided clock, sampled as asynchronous data
//   enable        in   level-sensitive monitor enable
//   rise_stb      out  one-cycle pulse per synchronized rising edge
//   fall_stb      out  one-cycle pulse per synchronized falling edge
//   period        out  last measured rise-to-rise period in clk_hf cycles
//   period_valid  out  period holds a real measurement
//   locked        out  divided clock verified at the expected period/duty
//   err_stb       out  one-cycle pulse per cycle with any detected fault
//   err_count     out  saturating fault counter, cleared only by reset

module clk_div_monitor #(
    parameter int DIV_LOG2    = 3,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk_hf,
    input  logic             rst_n,
    input  logic             clk_div_in,
    input  logic             enable,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err_stb,
    output logic [7:0]       err_count
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]  EXP      = CNT_W'(1 << DIV_LOG2);
    localparam logic [CNT_W-1:0]  HALF_EXP = CNT_W'(1 << (DIV_LOG2 - 1));
    localparam logic [CNT_W-1:0]  TIMEOUT  = CNT_W'(2 << DIV_LOG2);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_out;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [CNT_W-1:0]  period_nx;
    logic              period_valid_nx;
    logic [GOOD_W-1:0] good_cnt, good_nx;
    logic              locked_nx;
    logic              fault;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // The synchronizer chain is followed by a history flop. The strobes are
    // registered, so each one appears SYNC_STAGES+1 edges after the input
    // changes. Strobes are produced in every state, including IDLE.
    always_ff @(posedge clk_hf or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            hist_q   <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], clk_div_in};
            hist_q   <= sync_out;
            rise_stb <= sync_out & ~hist_q;
            fall_stb <= ~sync_out & hist_q;
        end
    end

    // Next-state and measurement logic. All faults detected in one cycle are
    // merged into a single fault flag, so they give one err_stb.
    // Deasserting enable overrides every other event.
    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        period_nx       = period;
        period_valid_nx = period_valid;
        good_nx         = good_cnt;
        locked_nx       = locked;
        fault           = 1'b0;

        if (!enable) begin
            state_nx        = IDLE;
            cnt_nx          = '0;
            period_valid_nx = 1'b0;
            good_nx         = '0;
            locked_nx       = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = ACQUIRE;
                    cnt_nx   = '0;
                end

                ACQUIRE: begin
                    cnt_nx = '0;
                    if (rise_stb) begin
                        cnt_nx   = CNT_W'(1);
                        state_nx = TRACK;
                    end
                end

                TRACK: begin
                    cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

                    // A rise takes priority over the timeout. A late rise
                    // is then scored as a period mismatch.
                    if (rise_stb) begin
                        cnt_nx          = CNT_W'(1);
                        period_nx       = cnt;
                        period_valid_nx = 1'b1;
                        if (cnt == EXP) begin
                            if (good_cnt != LOCK_TGT) begin
                                good_nx = good_cnt + GOOD_W'(1);
                            end
                            if (good_cnt >= LOCK_TGT - GOOD_W'(1)) begin
                                locked_nx = 1'b1;
                            end
                        end else begin
                            fault = 1'b1;
                        end
                    end else if (cnt == TIMEOUT) begin
                        fault    = 1'b1;
                        state_nx = ACQUIRE;
                        cnt_nx   = '0;
                    end

                    if (fall_stb && (cnt != HALF_EXP)) begin
                        fault = 1'b1;
                    end

                    if (fault) begin
                        good_nx   = '0;
                        locked_nx = 1'b0;
                    end
                end

                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // State, measurement and status registers. The error counter saturates
    // at 255, and only reset clears it.
    always_ff @(posedge clk_hf or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            good_cnt     <= '0;
            locked       <= 1'b0;
            err_stb      <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            period       <= period_nx;
            period_valid <= period_valid_nx;
            good_cnt     <= good_nx;
            locked       <= locked_nx;
            err_stb      <= fault;
            if (fault && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor
//
// Drives clk_div_in and enable with scripted and randomized divided-clock
// patterns. Every cycle it compares all DUT outputs against a
// timestamp-based behavioural model. Literal expectations at the end of
// each scenario pin the model to hand-derived values.
//
// Ports: none (top-level bench).

module tb_clk_div_monitor;

    localparam int EXP  = 8;
    localparam int LOCK = 4;

    logic       clk_hf = 1'b0;
    logic       rst_n;
    logic       clk_div_in;
    logic       enable;
    logic       rise_stb;
    logic       fall_stb;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       err_stb;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    // Model state. Time is the number of clk_hf edges seen since reset, and
    // the period counter is expressed as time elapsed since the last
    // accepted rise.
    int m_hist[$];
    int m_now;
    int m_last;
    int m_mode;      // 0 idle, 1 acquiring, 2 tracking
    int m_good;
    int m_period;
    int m_errcnt;
    bit m_rise, m_fall, m_pv, m_locked, m_err;

    always #5 clk_hf = ~clk_hf;

    clk_div_monitor #(
        .DIV_LOG2   (3),
        .SYNC_STAGES(2),
        .LOCK_COUNT (4),
        .CNT_W      (8)
    ) dut (
        .clk_hf      (clk_hf),
        .rst_n       (rst_n),
        .clk_div_in  (clk_div_in),
        .enable      (enable),
        .rise_stb    (rise_stb),
        .fall_stb    (fall_stb),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .err_stb     (err_stb),
        .err_count   (err_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic int past(input int d);
        if (m_hist.size() > d) return m_hist[m_hist.size() - 1 - d];
        return 0;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_now    = 0;
        m_last   = 0;
        m_mode   = 0;
        m_good   = 0;
        m_period = 0;
        m_errcnt = 0;
        m_rise   = 0;
        m_fall   = 0;
        m_pv     = 0;
        m_locked = 0;
        m_err    = 0;
    endtask

    task automatic model_step();
        int el;
        bit flt;
        flt = 0;
        m_now++;
        if (!enable) begin
            m_mode   = 0;
            m_pv     = 0;
            m_locked = 0;
            m_good   = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_rise) begin
                m_mode = 2;
                m_last = m_now;
            end
        end else begin
            el = m_now - m_last;
            if (m_rise) begin
                m_period = (el > 255) ? 255 : el;
                m_pv     = 1;
                m_last   = m_now;
                if (el == EXP) begin
                    if (m_good < LOCK) m_good++;
                    if (m_good == LOCK) m_locked = 1;
                end else begin
                    flt = 1;
                end
            end else if (el == 2 * EXP) begin
                flt    = 1;
                m_mode = 1;
            end
            if (m_fall && el != EXP / 2) flt = 1;
            if (flt) begin
                m_good   = 0;
                m_locked = 0;
            end
        end
        m_err = flt;
        if (flt && m_errcnt < 255) m_errcnt++;
        // The input is visible as a strobe three edges after it is sampled.
        m_hist.push_back(int'(clk_div_in));
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        m_rise = (past(2) == 1) && (past(3) == 0);
        m_fall = (past(2) == 0) && (past(3) == 1);
    endtask

    // Model process: it follows the same clock and asynchronous reset as the DUT.
    initial begin
        model_reset();
        forever begin
            @(posedge clk_hf or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare process: it checks every output against the model on each
    // falling edge.
    initial begin
        forever begin
            @(negedge clk_hf);
            checkOutput("rise_stb", 32'(rise_stb), 32'(m_rise));
            checkOutput("fall_stb", 32'(fall_stb), 32'(m_fall));
            checkOutput("period", 32'(period), 32'(m_period));
            checkOutput("period_valid", 32'(period_valid), 32'(m_pv));
            checkOutput("locked", 32'(locked), 32'(m_locked));
            checkOutput("err_stb", 32'(err_stb), 32'(m_err));
            checkOutput("err_count", 32'(err_count), 32'(m_errcnt));
        end
    end

    task automatic applyStimulus(input logic div, input logic en);
        @(posedge clk_hf);
        #2;
        clk_div_in = div;
        enable     = en;
    endtask

    task automatic run_div(input int per, input int hi, input int n,
                           input logic en);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < per; c++) begin
                applyStimulus(logic'(c < hi), en);
            end
        end
    endtask

    task automatic hold(input logic div, input int n, input logic en);
        for (int c = 0; c < n; c++) applyStimulus(div, en);
    endtask

    task automatic settle();
        @(negedge clk_hf);
        #1;
    endtask

    initial begin
        int per, hi;
        rst_n      = 1'b0;
        clk_div_in = 1'b0;
        enable     = 1'b0;
        repeat (3) @(posedge clk_hf);
        #2;
        rst_n = 1'b1;
        settle();
        checkOutput("reset_locked", 32'(locked), 32'd0);
        checkOutput("reset_err_count", 32'(err_count), 32'd0);

        // Clean clock, 4 high and 4 low. Lock comes after the acquire rise plus 4 good periods.
        hold(1'b0, 2, 1'b1);
        run_div(8, 4, 10, 1'b1);
        settle();
        checkOutput("clean_period", 32'(period), 32'd8);
        checkOutput("clean_locked", 32'(locked), 32'd1);
        checkOutput("clean_err_count", 32'(err_count), 32'd0);

        // One long period: the fall check and the rise check each fault once.
        run_div(10, 5, 1, 1'b1);
        run_div(8, 4, 1, 1'b1);
        settle();
        checkOutput("long_err_count", 32'(err_count), 32'd2);
        checkOutput("long_locked", 32'(locked), 32'd0);
        run_div(8, 4, 5, 1'b1);
        settle();
        checkOutput("relock_locked", 32'(locked), 32'd1);

        // Stopped clock: exactly one timeout, and the period is retained.
        hold(1'b0, 40, 1'b1);
        settle();
        checkOutput("timeout_err_count", 32'(err_count), 32'd3);
        checkOutput("timeout_locked", 32'(locked), 32'd0);
        checkOutput("timeout_period", 32'(period), 32'd8);
        run_div(8, 4, 8, 1'b1);
        settle();
        checkOutput("restart_locked", 32'(locked), 32'd1);

        // Duty fault: the period is correct but the high time is short.
        run_div(8, 3, 10, 1'b1);
        settle();
        checkOutput("duty_locked", 32'(locked), 32'd0);
        checkOutput("duty_period", 32'(period), 32'd8);

        // Enough faults to saturate the counter.
        run_div(10, 5, 160, 1'b1);
        settle();
        checkOutput("sat_err_count", 32'(err_count), 32'd255);

        // Disable while tracking: status clears, but period and count are retained.
        run_div(10, 5, 2, 1'b0);
        settle();
        checkOutput("dis_locked", 32'(locked), 32'd0);
        checkOutput("dis_period_valid", 32'(period_valid), 32'd0);
        checkOutput("dis_period", 32'(period), 32'd10);
        checkOutput("dis_err_count", 32'(err_count), 32'd255);
        run_div(8, 4, 10, 1'b1);
        settle();
        checkOutput("reen_locked", 32'(locked), 32'd1);

        // Asynchronous reset in the middle of a high phase.
        hold(1'b1, 2, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_locked", 32'(locked), 32'd0);
        checkOutput("arst_period", 32'(period), 32'd0);
        checkOutput("arst_err_count", 32'(err_count), 32'd0);
        checkOutput("arst_period_valid", 32'(period_valid), 32'd0);
        hold(1'b0, 3, 1'b1);
        rst_n = 1'b1;
        hold(1'b0, 2, 1'b1);
        run_div(8, 4, 1, 1'b1);
        settle();
        checkOutput("post_rst_period_valid", 32'(period_valid), 32'd0);
        checkOutput("post_rst_err_count", 32'(err_count), 32'd0);
        run_div(8, 4, 8, 1'b1);
        settle();
        checkOutput("post_rst_locked", 32'(locked), 32'd1);

        // Randomized mix of good and bad periods, dropouts and disables.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                per = $urandom_range(6, 12);
                hi  = $urandom_range(1, per - 1);
            end else begin
                per = 8;
                hi  = 4;
            end
            case ($urandom_range(0, 29))
                0:       hold(1'b0, $urandom_range(10, 24), 1'b1);
                1:       run_div(per, hi, 1, 1'b0);
                default: run_div(per, hi, 1, 1'b1);
            endcase
        end
        hold(1'b0, 20, 1'b1);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
